seg7_scan_driver: RTL and testbench
===================================

SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 SHALL have parameter DIGITS, default 8: number of multiplexed digits, legal range 1..16.
REQ-002 SHALL have parameter SCAN_DIV, default 100000: clock cycles each digit stays lit, legal range >=1.
REQ-003 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n  input  1  synchronous active-low reset.
REQ-005 SHALL have port i_load  input  1  capture strobe for i_data/i_blank.
REQ-006 SHALL have port i_data  input  4*DIGITS  BCD/hex nibbles; digit k = bits [4k+3:4k], digit 0 rightmost.
REQ-007 SHALL have port i_blank  input  DIGITS  per-digit blank request, 1 = blank.
REQ-008 SHALL have port o_seg  output  7  active-low segments {g,f,e,d,c,b,a}.
REQ-009 SHALL have port o_an  output  DIGITS  active-low digit enables, one-cold or all-high.
REQ-010 SHALL have port o_pending  output  1  captured data not yet on display.
REQ-011 SHALL have port o_frame  output  1  one-cycle pulse at each frame boundary.

Function
REQ-012 SHALL count a divider 0..SCAN_DIV-1; at terminal count, digit index advances k -> k+1, wrapping DIGITS-1 -> 0.
REQ-013 SHALL define frame boundary as terminal count with index DIGITS-1; o_frame high exactly that cycle.
REQ-014 SHALL latch i_data/i_blank into a shadow register on any cycle i_load=1 and set o_pending.
REQ-015 SHALL copy shadow into display register at frame boundary and clear o_pending, unless i_load is also 1 that cycle.
REQ-016 SHALL, when i_load coincides with a boundary, store new data in shadow, move previous shadow to display, keep o_pending=1.
REQ-017 SHALL register o_seg/o_an: they reflect the digit index one cycle after index changes.
REQ-018 SHALL drive o_an[k]=0 for the current index k, all other bits 1; a blanked digit drives o_an all-ones and o_seg=1111111.
REQ-019 SHALL decode 0..9 as 1000000,1111001,0100100,0110000,0011001,0010010,0000010,1111000,0000000,0010000.
REQ-020 SHALL, with DIGITS=1, hold o_an=0 continuously (unblanked) and pulse o_frame every SCAN_DIV cycles.
REQ-021 SHALL, with SCAN_DIV=1, advance index every cycle.

Reset
REQ-022 SHALL, on rst_n=0 at a clock edge, clear divider, index, shadow and display (all digits blanked) to 0 / blanked.
REQ-023 SHALL reset outputs: o_seg=1111111, o_an all-ones, o_pending=0, o_frame=0.
REQ-024 SHALL, on reset mid-frame, discard pending data and restart at digit 0 divider 0 on first cycle after release.

Configuration
REQ-025 SHALL, with SEG7_HEX_EN defined, decode 10..15 as A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-026 SHALL, without SEG7_HEX_EN, decode 10..15 as 1111111 (dark) with o_an still asserted for that digit.

Structure
REQ-027 SHALL place segment pattern constants (0..F, BLANK) and the 7-bit segment typedef in shared package seg7_pkg.
REQ-028 SHALL instantiate one combinational sub-module seg7_hex_decode (nibble -> pattern, honouring SEG7_HEX_EN).

Verification (DIGITS=4, SCAN_DIV=4)
REQ-029 SHALL check reset: hold rst_n=0 3 cycles -> o_seg=1111111, o_an=1111, o_pending=0, o_frame=0.
REQ-030 SHALL check scan: load i_data=16'h4321, i_blank=0 -> after next o_frame, o_an cycles 1110,1101,1011,0111 every 4 clocks with o_seg 1111001,0100100,0110000,0011001.
REQ-031 SHALL check tear-free update: load 16'h9999 mid-frame -> o_pending=1, segments unchanged until boundary, then 0010000 on all digits and o_pending=0.
REQ-032 SHALL check collision: i_load on boundary cycle -> o_pending stays 1, new value shown only after following boundary.
REQ-033 SHALL check hex/blank: i_data=16'hFA00, i_blank=4'b0001 -> digit0 o_an=1111; digit3 o_seg 0001110 with SEG7_HEX_EN, 1111111 without.
REQ-034 SHALL check reset mid-frame: assert rst_n=0 at digit 2 -> next released cycle index 0, outputs at reset values.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared segment types and patterns for the seg7 scan driver.
// Segment order is {g,f,e,d,c,b,a}, active low.
package seg7_pkg;

    typedef logic [6:0] seg_t;
    typedef logic [3:0] nibble_t;

    localparam seg_t SEG_0     = 7'b1000000;
    localparam seg_t SEG_1     = 7'b1111001;
    localparam seg_t SEG_2     = 7'b0100100;
    localparam seg_t SEG_3     = 7'b0110000;
    localparam seg_t SEG_4     = 7'b0011001;
    localparam seg_t SEG_5     = 7'b0010010;
    localparam seg_t SEG_6     = 7'b0000010;
    localparam seg_t SEG_7     = 7'b1111000;
    localparam seg_t SEG_8     = 7'b0000000;
    localparam seg_t SEG_9     = 7'b0010000;
    localparam seg_t SEG_A     = 7'b0001000;
    localparam seg_t SEG_B     = 7'b0000011;
    localparam seg_t SEG_C     = 7'b1000110;
    localparam seg_t SEG_D     = 7'b0100001;
    localparam seg_t SEG_E     = 7'b0000110;
    localparam seg_t SEG_F     = 7'b0001110;
    localparam seg_t SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Load/display bundle for the seg7 scan driver.
// master drives the load side, slave is the driver itself.
interface seg7_scan_driver_if #(
    parameter int DIGITS = 8
);
    import seg7_pkg::*;

    logic                  load;
    logic [4*DIGITS-1:0]   data;
    logic [DIGITS-1:0]     blank;
    seg_t                  seg;
    logic [DIGITS-1:0]     an;
    logic                  pending;
    logic                  frame;

    modport master (
        output load, data, blank,
        input  seg, an, pending, frame
    );

    modport slave (
        input  load, data, blank,
        output seg, an, pending, frame
    );

endinterface

// File: rtl/seg7_hex_decode.sv
// Nibble to active-low segment pattern.
// Letters A-F decode only when SEG7_HEX_EN is defined; otherwise dark.
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  nibble_t i_nib,
    output seg_t    o_seg
);

    always_comb begin
        o_seg = SEG_BLANK;
        unique case (i_nib)
            4'h0: o_seg = SEG_0;
            4'h1: o_seg = SEG_1;
            4'h2: o_seg = SEG_2;
            4'h3: o_seg = SEG_3;
            4'h4: o_seg = SEG_4;
            4'h5: o_seg = SEG_5;
            4'h6: o_seg = SEG_6;
            4'h7: o_seg = SEG_7;
            4'h8: o_seg = SEG_8;
            4'h9: o_seg = SEG_9;
`ifdef SEG7_HEX_EN
            4'hA: o_seg = SEG_A;
            4'hB: o_seg = SEG_B;
            4'hC: o_seg = SEG_C;
            4'hD: o_seg = SEG_D;
            4'hE: o_seg = SEG_E;
            4'hF: o_seg = SEG_F;
`endif
            default: o_seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed 7-segment scan driver with tear-free double buffering.
// Define SEG7_HEX_EN to show A-F; otherwise those digits stay dark.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int DIGITS   = 8,
    parameter int SCAN_DIV = 100000
)(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_load,
    input  logic [4*DIGITS-1:0] i_data,
    input  logic [DIGITS-1:0]   i_blank,
    output seg_t                o_seg,
    output logic [DIGITS-1:0]   o_an,
    output logic                o_pending,
    output logic                o_frame
);

    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [DW-1:0]       div_q, div_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [4*DIGITS-1:0] shd_data_q, shd_data_d;
    logic [DIGITS-1:0]   shd_blank_q, shd_blank_d;
    logic [4*DIGITS-1:0] dsp_data_q, dsp_data_d;
    logic [DIGITS-1:0]   dsp_blank_q, dsp_blank_d;
    logic                pend_q, pend_d;
    seg_t                seg_q, seg_d;
    logic [DIGITS-1:0]   an_q, an_d;

    logic    tc;
    logic    last;
    logic    frame;
    nibble_t cur_nib;
    logic    cur_blank;
    seg_t    dec_seg;

    seg7_hex_decode u_dec (
        .i_nib (cur_nib),
        .o_seg (dec_seg)
    );

    always_comb begin
        tc    = (div_q == DW'(SCAN_DIV - 1));
        last  = (idx_q == IW'(DIGITS - 1));
        frame = tc && last;

        div_d = tc ? '0 : div_q + 1'b1;
        idx_d = idx_q;
        if (tc) begin
            idx_d = last ? '0 : idx_q + 1'b1;
        end
    end

    // Boundary copy uses the old shadow, so a colliding load
    // lands in the shadow and keeps pending set.
    always_comb begin
        shd_data_d  = shd_data_q;
        shd_blank_d = shd_blank_q;
        dsp_data_d  = dsp_data_q;
        dsp_blank_d = dsp_blank_q;
        pend_d      = pend_q;
        if (frame) begin
            dsp_data_d  = shd_data_q;
            dsp_blank_d = shd_blank_q;
            pend_d      = 1'b0;
        end
        if (i_load) begin
            shd_data_d  = i_data;
            shd_blank_d = i_blank;
            pend_d      = 1'b1;
        end
    end

    always_comb begin
        cur_nib   = nibble_t'(dsp_data_q >> {idx_q, 2'b00});
        cur_blank = |(dsp_blank_q & (DIGITS'(1) << idx_q));
        seg_d     = cur_blank ? SEG_BLANK : dec_seg;
        an_d      = cur_blank ? '1 : ~(DIGITS'(1) << idx_q);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_q       <= '0;
            idx_q       <= '0;
            shd_data_q  <= '0;
            shd_blank_q <= '1;
            dsp_data_q  <= '0;
            dsp_blank_q <= '1;
            pend_q      <= 1'b0;
            seg_q       <= SEG_BLANK;
            an_q        <= '1;
        end else begin
            div_q       <= div_d;
            idx_q       <= idx_d;
            shd_data_q  <= shd_data_d;
            shd_blank_q <= shd_blank_d;
            dsp_data_q  <= dsp_data_d;
            dsp_blank_q <= dsp_blank_d;
            pend_q      <= pend_d;
            seg_q       <= seg_d;
            an_q        <= an_d;
        end
    end

    assign o_seg     = seg_q;
    assign o_an      = an_q;
    assign o_pending = pend_q;
    assign o_frame   = frame;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver at DIGITS=4, SCAN_DIV=4.
// Reference model works from elapsed cycles since reset release.
module tb_seg7_scan_driver;

    localparam int DIGITS   = 4;
    localparam int SCAN_DIV = 4;
    localparam int FRAME    = DIGITS * SCAN_DIV;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    seg7_scan_driver_if #(.DIGITS(DIGITS)) bus ();

    seg7_scan_driver #(
        .DIGITS   (DIGITS),
        .SCAN_DIV (SCAN_DIV)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_load    (bus.load),
        .i_data    (bus.data),
        .i_blank   (bus.blank),
        .o_seg     (bus.seg),
        .o_an      (bus.an),
        .o_pending (bus.pending),
        .o_frame   (bus.frame)
    );

    int checks = 0;
    int errors = 0;

    int          cyc;
    logic [15:0] m_shd_d, m_dsp_d;
    logic [3:0]  m_shd_b, m_dsp_b;
    logic        m_pend;
    logic [6:0]  e_seg;
    logic [3:0]  e_an;
    logic [6:0]  tbl [16];

    task automatic check(string tag, logic [15:0] got, logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(bit rst, bit ld, logic [15:0] d, logic [3:0] b);
        int k;
        @(negedge clk);
        rst_n     = !rst;
        bus.load  = ld;
        bus.data  = d;
        bus.blank = b;
        @(posedge clk);
        if (rst) begin
            cyc     = 0;
            m_shd_d = '0;
            m_shd_b = '1;
            m_dsp_d = '0;
            m_dsp_b = '1;
            m_pend  = 1'b0;
            e_seg   = 7'h7F;
            e_an    = 4'hF;
        end else begin
            k = (cyc / SCAN_DIV) % DIGITS;
            if (m_dsp_b[k]) begin
                e_seg = 7'h7F;
                e_an  = 4'hF;
            end else begin
                e_seg = tbl[m_dsp_d[4*k +: 4]];
                e_an  = 4'hF & ~(4'(1) << k);
            end
            if (cyc % FRAME == FRAME - 1) begin
                m_dsp_d = m_shd_d;
                m_dsp_b = m_shd_b;
                m_pend  = 1'b0;
            end
            if (ld) begin
                m_shd_d = d;
                m_shd_b = b;
                m_pend  = 1'b1;
            end
            cyc++;
        end
        #1;
        check("seg", 16'(bus.seg), 16'(e_seg));
        check("an", 16'(bus.an), 16'(e_an));
        check("pending", 16'(bus.pending), 16'(m_pend));
        check("frame", 16'(bus.frame), 16'(cyc % FRAME == FRAME - 1));
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) begin
            step(0, 0, 16'($urandom), 4'($urandom));
        end
    endtask

    initial begin
        tbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                7'b0000000, 7'b0010000,
`ifdef SEG7_HEX_EN
                7'b0001000, 7'b0000011, 7'b1000110,
                7'b0100001, 7'b0000110, 7'b0001110
`else
                7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F
`endif
               };
        cyc       = 0;
        bus.load  = 1'b0;
        bus.data  = '0;
        bus.blank = '0;

        // reset held three cycles
        for (int i = 0; i < 3; i++) step(1, 0, 16'h0, 4'h0);
        check("rst_seg", 16'(bus.seg), 16'h007F);
        check("rst_an", 16'(bus.an), 16'h000F);
        check("rst_pend", 16'(bus.pending), 16'h0);
        check("rst_frame", 16'(bus.frame), 16'h0);

        // basic scan of 4321
        idle(2);
        step(0, 1, 16'h4321, 4'h0);
        check("load_pend", 16'(bus.pending), 16'h1);
        idle(2 * FRAME + 2);
        check("scan_pend", 16'(bus.pending), 16'h0);

        // mid-frame update stays hidden until boundary
        idle(5);
        step(0, 1, 16'h9999, 4'h0);
        check("tear_pend", 16'(bus.pending), 16'h1);
        idle(2 * FRAME);

        // load on the boundary cycle
        for (int i = 0; i < FRAME && (cyc % FRAME) != FRAME - 1; i++) idle(1);
        step(0, 1, 16'h5678, 4'h0);
        check("coll_pend", 16'(bus.pending), 16'h1);
        idle(FRAME);
        check("coll_pend2", 16'(bus.pending), 16'h0);
        idle(FRAME);

        // letters and a blanked digit
        step(0, 1, 16'hFA00, 4'b0001);
        idle(2 * FRAME + 3);

        // random loads against the model
        for (int i = 0; i < 300; i++) begin
            step(0, ($urandom_range(0, 5) == 0), 16'($urandom), 4'($urandom));
        end

        // reset while scanning digit 2 with data pending
        step(0, 1, 16'h1234, 4'h0);
        for (int i = 0; i < FRAME && ((cyc / SCAN_DIV) % DIGITS) != 2; i++) idle(1);
        step(1, 0, 16'h0, 4'h0);
        step(0, 0, 16'h0, 4'h0);
        check("mrst_seg", 16'(bus.seg), 16'h007F);
        check("mrst_an", 16'(bus.an), 16'h000F);
        check("mrst_pend", 16'(bus.pending), 16'h0);
        idle(2 * FRAME);
        step(0, 1, 16'h0987, 4'h0);
        idle(2 * FRAME);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
